// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: field widths, binary32 field helpers
// and the exponent-alignment FSM state encoding.
package fpu_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int SIG_W   = 24;
    localparam int SHIFT_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } align_state_e;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [MANT_W-1:0] f_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

    // Significand with the hidden bit restored (0 for zero/denormal encodings).
    function automatic logic [SIG_W-1:0] f_sig(input logic [31:0] x);
        return {|f_exp(x), f_frac(x)};
    endfunction

    function automatic logic [EXP_W-1:0] f_eff_exp(input logic [31:0] x);
        return (f_exp(x) == '0) ? EXP_W'(1) : f_exp(x);
    endfunction

endpackage

// File: rtl/mantShiftRight.sv
// Zero-filling right shifter for a 24-bit significand; shifts of 24 or more
// flush the result to zero.
module mantShiftRight
    import fpu_pkg::*;
(
    input  logic [SIG_W-1:0]   mant_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [SIG_W-1:0]   mant_o
);

    always_comb begin
        if (shift_i >= SHIFT_W'(SIG_W)) begin
            mant_o = '0;
        end else begin
            mant_o = mant_i >> shift_i[4:0];
        end
    end

endmodule

// File: rtl/fp_align_ctrl.sv
// Exponent-alignment sequencer for the binary32 adder (IDLE->CMP->SHIFT->HOLD).
// Define FPU_STICKY_EN to generate the sticky bit; otherwise sticky is tied to 0.
module fp_align_ctrl
    import fpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        op_a,
    input  logic [31:0]        op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sign_big,
    output logic               sign_small,
    output logic [EXP_W-1:0]   exp_out,
    output logic [SIG_W-1:0]   mant_big,
    output logic [SIG_W-1:0]   mant_small,
    output logic               swapped,
    output logic               sticky
);

    align_state_e state_q, state_d;
    logic ld_op, ld_cmp, ld_out;

    logic [31:0]        op_a_q, op_b_q;
    logic               c_sign_big_q, c_sign_small_q, c_swapped_q;
    logic [EXP_W-1:0]   c_exp_q;
    logic [SIG_W-1:0]   c_mant_big_q, c_mant_pre_q;
    logic [SHIFT_W-1:0] c_shift_q;

    logic               sign_big_q, sign_small_q, swapped_q;
    logic [EXP_W-1:0]   exp_q;
    logic [SIG_W-1:0]   mant_big_q, mant_small_q;

    logic [EXP_W-1:0]   eff_a, eff_b;
    logic [SIG_W-1:0]   sig_a, sig_b, shifted;
    logic               b_big;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CMP;
            CMP:     state_d = SHIFT;
            SHIFT:   state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
        ld_op     = in_ready && in_valid;
        ld_cmp    = (state_q == CMP);
        ld_out    = (state_q == SHIFT);
    end

    // Magnitude compare uses the full significand so a min-normal beats any denormal.
    always_comb begin
        eff_a = f_eff_exp(op_a_q);
        eff_b = f_eff_exp(op_b_q);
        sig_a = f_sig(op_a_q);
        sig_b = f_sig(op_b_q);
        b_big = {eff_b, sig_b} > {eff_a, sig_a};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q         <= '0;
            op_b_q         <= '0;
            c_sign_big_q   <= 1'b0;
            c_sign_small_q <= 1'b0;
            c_swapped_q    <= 1'b0;
            c_exp_q        <= '0;
            c_mant_big_q   <= '0;
            c_mant_pre_q   <= '0;
            c_shift_q      <= '0;
        end else begin
            if (ld_op) begin
                op_a_q <= op_a;
                op_b_q <= op_b;
            end
            if (ld_cmp) begin
                c_swapped_q    <= b_big;
                c_sign_big_q   <= b_big ? f_sign(op_b_q) : f_sign(op_a_q);
                c_sign_small_q <= b_big ? f_sign(op_a_q) : f_sign(op_b_q);
                c_exp_q        <= b_big ? f_exp(op_b_q)  : f_exp(op_a_q);
                c_mant_big_q   <= b_big ? sig_b : sig_a;
                c_mant_pre_q   <= b_big ? sig_a : sig_b;
                c_shift_q      <= b_big ? ({1'b0, eff_b} - {1'b0, eff_a})
                                        : ({1'b0, eff_a} - {1'b0, eff_b});
            end
        end
    end

    mantShiftRight u_shift (
        .mant_i  (c_mant_pre_q),
        .shift_i (c_shift_q),
        .mant_o  (shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            swapped_q    <= 1'b0;
            exp_q        <= '0;
            mant_big_q   <= '0;
            mant_small_q <= '0;
        end else if (ld_out) begin
            sign_big_q   <= c_sign_big_q;
            sign_small_q <= c_sign_small_q;
            swapped_q    <= c_swapped_q;
            exp_q        <= c_exp_q;
            mant_big_q   <= c_mant_big_q;
            mant_small_q <= shifted;
        end
    end

`ifdef FPU_STICKY_EN
    logic [SIG_W-1:0] sticky_mask;
    logic             sticky_q;

    // Mask covers exactly the bits the shifter drops; saturates to all ones at 24+.
    always_comb begin
        if (c_shift_q >= SHIFT_W'(SIG_W)) begin
            sticky_mask = '1;
        end else begin
            sticky_mask = (SIG_W'(1) << c_shift_q[4:0]) - SIG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sticky_q <= 1'b0;
        else if (ld_out) sticky_q <= |(c_mant_pre_q & sticky_mask);
    end

    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    assign sign_big   = sign_big_q;
    assign sign_small = sign_small_q;
    assign swapped    = swapped_q;
    assign exp_out    = exp_q;
    assign mant_big   = mant_big_q;
    assign mant_small = mant_small_q;

endmodule

// File: doc/fp_align_ctrl.md
# fp_align_ctrl

Multi-cycle sequencer for the exponent-alignment step of the single-precision FP adder. It accepts two IEEE-754 binary32 operands over a valid/ready handshake and selects the larger-magnitude operand. It computes the exponent difference and drives the shared 24-bit mantissa right shifter to align the smaller mantissa. It then holds the aligned pair for the downstream add/normalise stage until that stage accepts it.

## Interface
Parameters: none; widths fixed by binary32.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- op_a  in  32  operand A, binary32
- op_b  in  32  operand B, binary32
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- sign_big  out  1  sign of larger-magnitude operand
- sign_small  out  1  sign of smaller operand
- exp_out  out  8  biased exponent of larger operand
- mant_big  out  24  larger mantissa incl. hidden bit
- mant_small  out  24  smaller mantissa, right-shifted by exponent difference
- swapped  out  1  1 = B was larger
- sticky  out  1  OR of bits shifted out of mant_small

## Operation
- Hidden bit: 1 if exponent field != 0, else 0.
- Denormals: exponent field 0 uses effective exponent 1.
- Magnitude compare: compare {eff_exp, mantissa}; B is big only if strictly greater. Ties give A as big and swapped=0.
- shift = eff_exp_big - eff_exp_small, 9-bit unsigned, range 0..254.
- The shifter zero-fills. shift >= 24 gives mant_small = 0.
- NaN/Inf are not special-cased; they pass through as ordinary encodings.
- FSM states:
  - IDLE: in_ready=1. in_valid&in_ready moves to CMP; operands are registered.
  - CMP: compare, swap, register shift, big fields and small mantissa; moves to SHIFT.
  - SHIFT: shifter output and sticky are registered into the output regs; moves to HOLD.
  - HOLD: out_valid=1. out_ready moves to IDLE; otherwise stays.
- in_ready is decoded as state==IDLE. Inputs are ignored outside IDLE.
- Output registers change only on the SHIFT->HOLD edge and are stable throughout HOLD.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, all data outputs 0.
- Accept at edge k; out_valid rises at edge k+2. Latency is 2 cycles.
- Minimum initiation interval is 4 cycles: IDLE, CMP, SHIFT, HOLD, with out_ready high in HOLD.
- The out handshake completes at the edge where out_valid&out_ready. out_valid falls and in_ready rises at that edge.
- A new accept is possible at the following edge.
- out_ready high before HOLD has no effect.
- Reset mid-operation: all state and outputs clear immediately. The in-flight pair is discarded with no partial output.

## Configuration
- FPU_STICKY_EN defined: sticky = OR of mant_small_pre[min(shift,24)-1:0], computed in CMP/SHIFT.
  - shift=0 gives 0.
  - shift >= 24 gives OR of the whole small mantissa.
- FPU_STICKY_EN undefined: sticky port remains and is tied to 0; no masking logic is generated.

## Structure
- Shared package fpu_pkg holds:
  - EXP_W=8, MANT_W=23, SIG_W=24, SHIFT_W=9
  - binary32 field-extract helpers
  - the align FSM state enum (IDLE, CMP, SHIFT, HOLD)
- Sub-module: one instance of mantShiftRight (24-bit mantissa, 9-bit shift, zero-fill, zero output for shift >= 24). It is driven from the CMP-stage registers.
- Sticky mask logic stays in fp_align_ctrl.

## Test plan
- A=0x40000000, B=0x3F800000 -> exp_out=0x80, mant_big=0x800000, mant_small=0x400000, swapped=0, sticky=0; out_valid 2 cycles after accept.
- A=0x3F800000, B=0x41200000 -> swapped=1, exp_out=0x82, mant_big=0xA00000, mant_small=0x100000 (shift 3), sticky=0.
- A=0x40000000, B=0x3F800001 -> mant_small=0x400000; sticky=1 with FPU_STICKY_EN, 0 without.
- A=0x4B800000, B=0x3F800001 (shift 24) -> mant_small=0x000000, sticky=1 (macro on), exp_out=0x97.
- A=B=0xBF800000 -> swapped=0, sign_big=1, sign_small=1, mant_small=0x800000.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, in_valid pulses ignored; release gives one handshake, then in_ready=1.
  - Assert rst_n=0 during SHIFT -> out_valid=0, in_ready=1, outputs 0 immediately; no stale result afterwards.
